// File: rtl/fft_bf2_stage16.sv
// Radix-2 SDF butterfly for the 16-delay stage of the 64-point FFT.
// Pairs samples n and n+16 through the external shift_16 line and twiddles the differences by W32^n.
module fft_bf2_stage16 #(
  parameter int DW = 24,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  input  logic [DW-1:0] dly_in_r,
  input  logic [DW-1:0] dly_in_i,
  output logic [DW-1:0] dly_out_r,
  output logic [DW-1:0] dly_out_i,
  output logic          dly_en,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i,
  output logic          out_valid
);

  localparam int PW = DW + TW + 1;
  localparam logic signed [PW-1:0] RND = PW'(8192);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} state_t;

  state_t state, state_next;
  logic [4:0] cnt;
  logic adv, phase, ov_next;

  logic signed [DW-1:0] x_r, x_i, a_r, a_i;
  logic signed [DW-1:0] sum_r, sum_i, dif_r, dif_i;
  logic signed [DW-1:0] tw_r, tw_i, res_r, res_i;
  logic signed [TW-1:0] c, s;
  logic signed [PW-1:0] full_r, full_i, shr_r, shr_i;

  assign adv    = in_valid | (state != ST_IDLE);
  assign phase  = cnt[4];
  assign dly_en = adv;

  // Flush cycles feed zeros so a trailing frame still completes.
  assign x_r = in_valid ? din_r : '0;
  assign x_i = in_valid ? din_i : '0;
  assign a_r = dly_in_r;
  assign a_i = dly_in_i;

  assign sum_r = a_r + x_r;
  assign sum_i = a_i + x_i;
  assign dif_r = a_r - x_r;
  assign dif_i = a_i - x_i;

  assign dly_out_r = phase ? dif_r : x_r;
  assign dly_out_i = phase ? dif_i : x_i;

  // W32^k = c - j*s, Q2.14
  always_comb begin
    c = '0;
    s = '0;
    case (cnt[3:0])
      4'd0:  begin c = TW'(16384);  s = TW'(0);     end
      4'd1:  begin c = TW'(16069);  s = TW'(3196);  end
      4'd2:  begin c = TW'(15137);  s = TW'(6270);  end
      4'd3:  begin c = TW'(13623);  s = TW'(9102);  end
      4'd4:  begin c = TW'(11585);  s = TW'(11585); end
      4'd5:  begin c = TW'(9102);   s = TW'(13623); end
      4'd6:  begin c = TW'(6270);   s = TW'(15137); end
      4'd7:  begin c = TW'(3196);   s = TW'(16069); end
      4'd8:  begin c = TW'(0);      s = TW'(16384); end
      4'd9:  begin c = TW'(-3196);  s = TW'(16069); end
      4'd10: begin c = TW'(-6270);  s = TW'(15137); end
      4'd11: begin c = TW'(-9102);  s = TW'(13623); end
      4'd12: begin c = TW'(-11585); s = TW'(11585); end
      4'd13: begin c = TW'(-13623); s = TW'(9102);  end
      4'd14: begin c = TW'(-15137); s = TW'(6270);  end
      default: begin c = TW'(-16069); s = TW'(3196); end
    endcase
  end

  always_comb begin
    full_r = PW'(a_r) * PW'(c) + PW'(a_i) * PW'(s);
    full_i = PW'(a_i) * PW'(c) - PW'(a_r) * PW'(s);
    shr_r  = (full_r + RND) >>> 14;
    shr_i  = (full_i + RND) >>> 14;
    tw_r   = shr_r[DW-1:0];
    tw_i   = shr_i[DW-1:0];
    res_r  = phase ? sum_r : tw_r;
    res_i  = phase ? sum_i : tw_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FILL covers the first phase 0, where the delay line holds nothing yet.
  always_comb begin
    state_next = state;
    ov_next    = phase | (state == ST_RUN);
    case (state)
      ST_IDLE: if (in_valid) state_next = ST_FILL;
      ST_FILL: if (phase)    state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      dout_r    <= '0;
      dout_i    <= '0;
      out_valid <= 1'b0;
    end else if (adv) begin
      cnt       <= cnt + 5'd1;
      dout_r    <= res_r;
      dout_i    <= res_i;
      out_valid <= ov_next;
    end
  end

endmodule

// File: tb/tb_fft_bf2_stage16.sv
// Scoreboard bench for fft_bf2_stage16 with a 16-deep behavioural shift_16 model.
module tb_fft_bf2_stage16;
  localparam int DW = 24;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] din_r, din_i, dly_in_r, dly_in_i;
  logic [DW-1:0] dly_out_r, dly_out_i, dout_r, dout_i;
  logic          dly_en, out_valid;

  int checks = 0;
  int errors = 0;
  logic done = 1'b0;

  logic [2*DW-1:0] expq[$];
  logic [2*DW-1:0] dl[16];

  int fr[32], fi[32];
  int es_r[16], es_i[16], ed_r[16], ed_i[16];

  fft_bf2_stage16 #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .din_r(din_r), .din_i(din_i),
    .dly_in_r(dly_in_r), .dly_in_i(dly_in_i),
    .dly_out_r(dly_out_r), .dly_out_i(dly_out_i), .dly_en(dly_en),
    .dout_r(dout_r), .dout_i(dout_i), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial for (int k = 0; k < 16; k++) dl[k] = '0;

  assign dly_in_r = dl[15][2*DW-1:DW];
  assign dly_in_i = dl[15][DW-1:0];

  always @(posedge clk) begin
    if (dly_en) begin
      for (int k = 15; k > 0; k--) dl[k] <= dl[k-1];
      dl[0] <= {dly_out_r, dly_out_i};
    end
  end

  always @(negedge clk) begin
    if (!done && rst_n === 1'b1 && out_valid === 1'b1) begin
      logic [2*DW-1:0] e;
      logic signed [DW-1:0] er, ei;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL dout_unexpected: got (%0d,%0d) required no output", $signed(dout_r), $signed(dout_i));
      end else begin
        e  = expq.pop_front();
        er = e[2*DW-1:DW];
        ei = e[DW-1:0];
        if ({dout_r, dout_i} !== e) begin
          errors++;
          $display("FAIL dout: got (%0d,%0d) required (%0d,%0d) at %0t",
                   $signed(dout_r), $signed(dout_i), er, ei, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not end, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic drive(input logic v, input int r, input int i);
    in_valid = v;
    din_r    = DW'(r);
    din_i    = DW'(i);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int r, input int i);
    logic [DW-1:0] pr, pi;
    pr = DW'(r);
    pi = DW'(i);
    expq.push_back({pr, pi});
  endtask

  task automatic clear_all();
    for (int k = 0; k < 32; k++) begin fr[k] = 0; fi[k] = 0; end
    for (int k = 0; k < 16; k++) begin es_r[k] = 0; es_i[k] = 0; ed_r[k] = 0; ed_i[k] = 0; end
  endtask

  task automatic push_frame_exp();
    for (int k = 0; k < 16; k++) push(es_r[k], es_i[k]);
    for (int k = 0; k < 16; k++) push(ed_r[k], ed_i[k]);
  endtask

  task automatic send_frame();
    for (int k = 0; k < 32; k++) drive(1'b1, fr[k], fi[k]);
  endtask

  task automatic flush(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 0, 0);
      check("flush_dly_en", int'(dly_en), 1);
    end
  endtask

  task automatic impulse_frame();
    clear_all();
    fr[0] = 1000; es_r[0] = 1000; ed_r[0] = 1000;
    push_frame_exp();
    send_frame();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; din_r = '0; din_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout_r", int'($signed(dout_r)), 0);
    check("reset_dout_i", int'($signed(dout_i)), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_dly_en", int'(dly_en), 0);
    rst_n = 1'b1;
    drive(1'b0, 0, 0);
    drive(1'b0, 0, 0);
    check("idle_out_valid", int'(out_valid), 0);
    check("idle_dly_en", int'(dly_en), 0);

    impulse_frame();

    clear_all();
    for (int k = 0; k < 32; k++) begin fr[k] = 100; fi[k] = 50; end
    for (int k = 0; k < 16; k++) begin es_r[k] = 200; es_i[k] = 100; end
    push_frame_exp();
    send_frame();

    clear_all();
    fr[4] = 1000; fr[8] = 1000;
    es_r[4] = 1000; es_r[8] = 1000;
    ed_r[4] = 707; ed_i[4] = -707;
    ed_r[8] = 0;   ed_i[8] = -1000;
    push_frame_exp();
    send_frame();

    clear_all();
    fr[0] = 8388607; fr[16] = 8388607;
    es_r[0] = -2;
    push_frame_exp();
    send_frame();

    for (int k = 0; k < 16; k++) push(0, 0);
    flush(32);
    check("flush_out_valid", int'(out_valid), 1);

    // Flush-frame diffs, then the first three sums of a partial frame.
    for (int k = 0; k < 16; k++) push(0, 0);
    push(500, 0); push(0, 0); push(0, 0);
    drive(1'b1, 500, 0);
    for (int k = 1; k < 20; k++) drive(1'b1, 0, 0);
    in_valid = 1'b0; din_r = '0; din_i = '0;
    rst_n = 1'b0;
    #1;
    check("midreset_dout_r", int'($signed(dout_r)), 0);
    check("midreset_dout_i", int'($signed(dout_i)), 0);
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_dly_en", int'(dly_en), 0);
    check("pre_reset_drained", expq.size(), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    impulse_frame();
    for (int k = 0; k < 16; k++) push(0, 0);
    flush(32);
    @(negedge clk);
    #1;
    check("final_drained", expq.size(), 0);
    done = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
